// File: rtl/stream_to_axi_b.sv
// ----------------------------------------------------------------------------
// stream_to_axi_b
//   Receiving end of the B-channel snoop stream. Each stream beat carries
//   {type, bid, pad, bresp}. Beats whose type tag matches STREAM_TYPE and
//   which are marked last are buffered in a small FIFO. Every buffered entry is
//   replayed as one AXI4 write response on the master B port. All other
//   accepted beats are discarded and counted.
//
//   Stream handshake: a beat transfers on a rising edge where
//   s_tvalid && s_tready. AXI handshake: a response transfers on a rising edge
//   where AXIM_bvalid && AXIM_bready. While bvalid is high and bready is low,
//   bid, bresp and bvalid hold stable.
//
// Ports
//   clk, resetn              clock (rising edge), asynchronous active-low reset
//   s_tdata/tvalid/tlast     stream beat input
//   s_tready                 stream ready (low while full or in reset)
//   AXIM_bid/bresp/buser     replayed response (buser is always 0)
//   AXIM_bvalid/bready       response handshake
//   drop_count               saturating count of discarded beats
//   fifo_level               number of buffered responses
// ----------------------------------------------------------------------------
module stream_to_axi_b #(
    parameter int DATA_WIDTH        = 128,
    parameter int ID_WIDTH          = 32,
    parameter int USER_WIDTH        = 64,
    parameter int STREAM_TYPE_WIDTH = 3,
    parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE = '0,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [DATA_WIDTH-1:0]           s_tdata,
    input  logic                            s_tvalid,
    input  logic                            s_tlast,
    output logic                            s_tready,
    output logic [ID_WIDTH-1:0]             AXIM_bid,
    output logic [1:0]                      AXIM_bresp,
    output logic [USER_WIDTH-1:0]           AXIM_buser,
    output logic                            AXIM_bvalid,
    input  logic                            AXIM_bready,
    output logic [15:0]                     drop_count,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = ID_WIDTH + 2;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [EW-1:0] head;
    logic          ready_en;
    logic          full;
    logic          empty;
    logic          accept;
    logic          push;
    logic          drop;
    logic          pop;

    logic [STREAM_TYPE_WIDTH-1:0] beat_type;
    logic [ID_WIDTH-1:0]          beat_bid;
    logic [1:0]                   beat_bresp;

    // Pad bits between bid and bresp carry no information.
    logic unused_tdata;
    assign unused_tdata = ^s_tdata;

    assign beat_type  = s_tdata[DATA_WIDTH-1 -: STREAM_TYPE_WIDTH];
    assign beat_bid   = s_tdata[DATA_WIDTH-STREAM_TYPE_WIDTH-1 -: ID_WIDTH];
    assign beat_bresp = s_tdata[1:0];

    // Extra pointer MSB distinguishes full from empty when low bits match.
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // ready_en keeps s_tready low from reset assertion until the first edge
    // after release.
    assign s_tready = ready_en && !full;
    assign accept   = s_tvalid && s_tready;
    assign push     = accept && (beat_type == STREAM_TYPE) && s_tlast;
    assign drop     = accept && !push;
    assign pop      = AXIM_bvalid && AXIM_bready;

    assign head        = mem[rd_ptr[AW-1:0]];
    assign AXIM_bvalid = !empty;
    assign AXIM_bid    = empty ? '0 : head[EW-1:2];
    assign AXIM_bresp  = empty ? 2'b00 : head[1:0];
    assign AXIM_buser  = '0;
    assign fifo_level  = wr_ptr - rd_ptr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ready_en   <= 1'b0;
            drop_count <= '0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    // Storage is only read through the empty-qualified head mux, so it
    // needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {beat_bid, beat_bresp};
        end
    end

endmodule

// File: tb/tb_stream_to_axi_b.sv
// ----------------------------------------------------------------------------
// tb_stream_to_axi_b
//   Directed bench for stream_to_axi_b. A queue model of the response buffer
//   is advanced on every clock edge; a compare process checks all DUT outputs
//   against it on every falling edge. Directed scenarios add literal checks.
// ----------------------------------------------------------------------------
module tb_stream_to_axi_b;

    localparam int DW    = 128;
    localparam int IW    = 32;
    localparam int UW    = 64;
    localparam int STW   = 3;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int PADW  = DW - STW - IW - 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0]  s_tdata = '0;
    logic           s_tvalid = 1'b0;
    logic           s_tlast = 1'b0;
    logic           s_tready;
    logic [IW-1:0]  AXIM_bid;
    logic [1:0]     AXIM_bresp;
    logic [UW-1:0]  AXIM_buser;
    logic           AXIM_bvalid;
    logic           AXIM_bready = 1'b0;
    logic [15:0]    drop_count;
    logic [LW-1:0]  fifo_level;

    stream_to_axi_b #(
        .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW),
        .STREAM_TYPE_WIDTH(STW), .STREAM_TYPE(3'b000), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .resetn(resetn),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .AXIM_bid(AXIM_bid), .AXIM_bresp(AXIM_bresp), .AXIM_buser(AXIM_buser),
        .AXIM_bvalid(AXIM_bvalid), .AXIM_bready(AXIM_bready),
        .drop_count(drop_count), .fifo_level(fifo_level)
    );

    // ---------------- counters ----------------
    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Scoreboard: expected responses in order, each {bid, bresp}.
    logic [IW+1:0] exp_q[$];
    int            exp_drop = 0;
    bit            exp_ready_en = 0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exp_q.delete();
            exp_drop     = 0;
            exp_ready_en = 0;
        end else begin
            bit acc, good, do_pop;
            acc    = s_tvalid && exp_ready_en && (exp_q.size() < DEPTH);
            good   = acc && (s_tdata[DW-1 -: STW] == 3'b000) && s_tlast;
            do_pop = (exp_q.size() > 0) && AXIM_bready;
            if (do_pop) void'(exp_q.pop_front());
            if (good) exp_q.push_back({s_tdata[DW-STW-1 -: IW], s_tdata[1:0]});
            if (acc && !good && exp_drop < 65535) exp_drop++;
            exp_ready_en = 1;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [IW+1:0] h;
        h = (exp_q.size() > 0) ? exp_q[0] : '0;
        chk("s_tready", s_tready, exp_ready_en && (exp_q.size() < DEPTH));
        chk("bvalid", AXIM_bvalid, exp_q.size() > 0);
        chk("bid", AXIM_bid, h[IW+1:2]);
        chk("bresp", AXIM_bresp, h[1:0]);
        chk("buser", AXIM_buser, 0);
        chk("fifo_level", fifo_level, exp_q.size());
        chk("drop_count", drop_count, exp_drop);
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mk(input logic [STW-1:0] t, input logic [IW-1:0] id,
                                         input logic [1:0] r);
        logic [PADW-1:0] pad;
        pad = {$urandom, $urandom, $urandom};
        return {t, id, pad, r};
    endfunction

    task automatic drive(input logic [STW-1:0] t, input logic [IW-1:0] id,
                         input logic [1:0] r, input logic last);
        s_tdata  = mk(t, id, r);
        s_tlast  = last;
        s_tvalid = 1'b1;
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        int n;
        AXIM_bready = 1'b1;
        n = 0;
        while (AXIM_bvalid && n < 50) begin cyc(); n++; end
        chk("drain_done", AXIM_bvalid, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int accepted, budget;
        #2;
        // Reset state
        chk("rst_tready", s_tready, 0);
        chk("rst_bvalid", AXIM_bvalid, 0);
        chk("rst_bid", AXIM_bid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_drop", drop_count, 0);
        cyc(); cyc();
        resetn = 1'b1;
        cyc();
        chk("post_rst_tready", s_tready, 1);

        // 1. Single good beat
        AXIM_bready = 1'b1;
        drive(3'b000, 32'hA5, 2'b10, 1'b1);
        cyc();
        idle();
        chk("t1_bvalid", AXIM_bvalid, 1);
        chk("t1_bid", AXIM_bid, 32'hA5);
        chk("t1_bresp", AXIM_bresp, 2'b10);
        chk("t1_level", fifo_level, 1);
        cyc();
        chk("t1_bvalid_off", AXIM_bvalid, 0);
        chk("t1_level0", fifo_level, 0);

        // 2. Back-to-back fill, then drain in order
        AXIM_bready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(3'b000, i, i[1:0], 1'b1);
            cyc();
        end
        idle();
        chk("t2_level", fifo_level, 4);
        chk("t2_tready", s_tready, 0);
        AXIM_bready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t2_bvalid", AXIM_bvalid, 1);
            chk("t2_bid", AXIM_bid, i);
            cyc();
        end
        chk("t2_empty", AXIM_bvalid, 0);

        // 3. Filtering
        chk("t3_tready_a", s_tready, 1);
        drive(3'b101, 32'h11, 2'b01, 1'b1);
        cyc();
        chk("t3_tready_b", s_tready, 1);
        drive(3'b000, 32'h22, 2'b01, 1'b0);
        cyc();
        idle();
        chk("t3_drop", drop_count, 2);
        chk("t3_bvalid", AXIM_bvalid, 0);

        // 4. Random backpressure, 100 beats (occasional bad type/tlast)
        accepted = 0;
        budget = 0;
        while (accepted < 100 && budget < 3000) begin
            AXIM_bready = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) != 0)
                drive(($urandom_range(0, 7) == 0) ? 3'b110 : 3'b000, $urandom, 2'($urandom_range(0, 3)),
                      $urandom_range(0, 15) != 0);
            else
                idle();
            #3;
            if (s_tvalid && s_tready) accepted++;
            @(posedge clk); #1;
            budget++;
        end
        idle();
        chk("t4_accepted", accepted, 100);
        drain();

        // 5. Simultaneous push/pop at level 2
        AXIM_bready = 1'b0;
        drive(3'b000, 32'h100, 2'b00, 1'b1); cyc();
        drive(3'b000, 32'h101, 2'b01, 1'b1); cyc();
        chk("t5_level_start", fifo_level, 2);
        AXIM_bready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(3'b000, 32'h200 + i, 2'(i), 1'b1);
            cyc();
            chk("t5_level", fifo_level, 2);
        end
        idle();
        chk("t5_head", AXIM_bid, 32'h208);
        drain();

        // 6. Reset mid-stream at level 3
        AXIM_bready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(3'b000, 32'h300 + i, 2'b11, 1'b1);
            cyc();
        end
        idle();
        chk("t6_level3", fifo_level, 3);
        #2 resetn = 1'b0;
        #1;
        chk("t6_bvalid", AXIM_bvalid, 0);
        chk("t6_level", fifo_level, 0);
        chk("t6_tready", s_tready, 0);
        cyc(); cyc();
        resetn = 1'b1;
        cyc();
        AXIM_bready = 1'b1;
        drive(3'b000, 32'h77, 2'b01, 1'b1);
        cyc();
        idle();
        chk("t6_bid", AXIM_bid, 32'h77);
        chk("t6_bresp", AXIM_bresp, 2'b01);
        chk("t6_drop", drop_count, 0);
        cyc();
        chk("t6_done", AXIM_bvalid, 0);
        cyc();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
